// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler output path.
//   state_e           : readout FSM encoding (IDLE=0, LOAD=1, STREAM=2, DONE=3)
//   DataWDefault      : default bits per channel sample
//   index_width()     : width of a sample index for a W x H x CHANNEL frame, one spare bit
//                       so DEPTH itself is representable for range checks
//   mem_addr_width()  : address bits needed to index DEPTH storage entries (minimum 1)
package scaler_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StStream = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam int unsigned DataWDefault = 8;

    function automatic int unsigned index_width(input int unsigned w, input int unsigned h,
                                                input int unsigned ch);
        return $clog2(w * h * ch) + 1;
    endfunction

    function automatic int unsigned mem_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/res_stream_out_if.sv
// Output stream of the scaler readout: valid/ready beats carrying one channel sample each,
// with frame/row markers.
//   m_valid : beat valid (master -> slave)
//   m_ready : beat accepted (slave -> master)
//   m_data  : channel sample
//   m_sof   : first beat of frame
//   m_eol   : last beat of a row
//   m_eof   : last beat of frame
interface res_stream_out_if
    import scaler_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) ();

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output m_valid,
        output m_data,
        output m_sof,
        output m_eol,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_sof,
        input  m_eol,
        input  m_eof,
        output m_ready
    );

endinterface

// File: rtl/res_frame_mem.sv
// Frame store: DEPTH x DATA_W, one write port and one registered read port.
//   clk, rst : clock; asynchronous active-high reset (clears only the read register)
//   wr_en    : write strobe, wr_addr/wr_data written on the clock edge
//   rd_en    : load rd_data with mem[rd_addr] on the clock edge; rd_data holds otherwise
//   rd_data  : registered read data
module res_frame_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MAW-1:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [MAW-1:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the stream data register: holding it while rd_en is low
    // keeps m_data stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/res_stream_out.sv
// Readout end of the scaler output buffer. Captures sample writes from the mapping FSM while
// idle, then on a frame_done rising edge streams the whole frame in raster order
// (pixel-major, channel-minor) with sof/eol/eof markers.
//   clk, rst   : clock; asynchronous active-high reset
//   wr_en      : sample write strobe (accepted only while idle and wr_addr < DEPTH)
//   wr_addr    : sample index ((y*W_out+x)*CHANNEL+c)
//   wr_data    : sample value
//   frame_done : level, rising edge starts one stream
//   m_if       : output stream (master side)
//   busy       : high while loading or streaming
module res_stream_out
    import scaler_pkg::*;
#(
    parameter int unsigned W_out   = 4,
    parameter int unsigned H_out   = 4,
    parameter int unsigned CHANNEL = 1,
    parameter int unsigned DATA_W  = DataWDefault,
    localparam int unsigned DEPTH  = W_out * H_out * CHANNEL,
    localparam int unsigned AW     = index_width(W_out, H_out, CHANNEL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              frame_done,
    res_stream_out_if.master  m_if,
    output logic              busy
);

    localparam int unsigned MAW = mem_addr_width(DEPTH);
    localparam int unsigned CW  = $clog2(CHANNEL) + 1;
    localparam int unsigned XW  = $clog2(W_out) + 1;
    localparam int unsigned YW  = $clog2(H_out) + 1;

    state_e          state_q, state_d;
    logic            fd_q;
    logic [AW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   c_q, c_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            valid_q, valid_d;

    logic            mem_wr_en;
    logic            rd_en;
    logic [MAW-1:0]  rd_addr;
    logic            last_c, last_x, last_y, last_beat, handshake;

    assign mem_wr_en = wr_en && (state_q == StIdle) && (wr_addr < AW'(DEPTH));

    assign last_c    = (c_q == CW'(CHANNEL - 1));
    assign last_x    = (x_q == XW'(W_out - 1));
    assign last_y    = (y_q == YW'(H_out - 1));
    assign last_beat = (idx_q == AW'(DEPTH - 1));
    assign handshake = valid_q && m_if.m_ready;

    res_frame_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .MAW    (MAW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_addr[MAW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (m_if.m_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        rd_en   = 1'b0;
        // Lookahead: on an accepted beat the read port fetches the following sample so the
        // next beat is ready one cycle later.
        rd_addr = MAW'(idx_q + AW'(1));

        unique case (state_q)
            StIdle: begin
                if (frame_done && !fd_q) begin
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                idx_d   = '0;
                c_d     = '0;
                x_d     = '0;
                y_d     = '0;
                valid_d = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                if (handshake) begin
                    if (last_beat) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        rd_en = 1'b1;
                        idx_d = idx_q + AW'(1);
                        if (last_c) begin
                            c_d = '0;
                            if (last_x) begin
                                x_d = '0;
                                y_d = last_y ? '0 : y_q + YW'(1);
                            end else begin
                                x_d = x_q + XW'(1);
                            end
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            StDone: begin
                // A frame_done held high must not restart the stream.
                if (!frame_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            fd_q    <= 1'b0;
            idx_q   <= '0;
            c_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fd_q    <= frame_done;
            idx_q   <= idx_d;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    // Markers come from the position counters of the presented beat, gated by valid so they
    // read 0 outside a beat.
    assign m_if.m_valid = valid_q;
    assign m_if.m_sof   = valid_q && (c_q == '0) && (x_q == '0) && (y_q == '0);
    assign m_if.m_eol   = valid_q && last_c && last_x;
    assign m_if.m_eof   = valid_q && last_c && last_x && last_y;

    assign busy = (state_q == StLoad) || (state_q == StStream);

endmodule

// File: tb/tb_res_stream_out.sv
// Bench for res_stream_out: two instances (4x4x1 and 4x2x3) driven with random data and
// random/patterned backpressure, checked against a frame model held in ref_mem.
module tb_res_stream_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en [2];
    logic [4:0] wr_addr0;
    logic [5:0] wr_addr1;
    logic [7:0] wr_data [2];
    logic       frame_done [2];
    logic       ready [2];
    logic       busy [2];

    logic       s_valid [2];
    logic [7:0] s_data [2];
    logic [2:0] s_flags [2];

    res_stream_out_if #(.DATA_W(8)) if0 ();
    res_stream_out_if #(.DATA_W(8)) if1 ();

    assign if0.m_ready = ready[0];
    assign if1.m_ready = ready[1];
    assign s_valid[0]  = if0.m_valid;
    assign s_valid[1]  = if1.m_valid;
    assign s_data[0]   = if0.m_data;
    assign s_data[1]   = if1.m_data;
    assign s_flags[0]  = {if0.m_sof, if0.m_eol, if0.m_eof};
    assign s_flags[1]  = {if1.m_sof, if1.m_eol, if1.m_eof};

    res_stream_out #(
        .W_out   (4),
        .H_out   (4),
        .CHANNEL (1),
        .DATA_W  (8)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en[0]),
        .wr_addr    (wr_addr0),
        .wr_data    (wr_data[0]),
        .frame_done (frame_done[0]),
        .m_if       (if0),
        .busy       (busy[0])
    );

    res_stream_out #(
        .W_out   (4),
        .H_out   (2),
        .CHANNEL (3),
        .DATA_W  (8)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en[1]),
        .wr_addr    (wr_addr1),
        .wr_data    (wr_data[1]),
        .frame_done (frame_done[1]),
        .m_if       (if1),
        .busy       (busy[1])
    );

    int         depth [2]   = '{16, 24};
    int         row_len [2] = '{4, 12};
    logic [7:0] ref_mem [2][32];
    int         checks      = 0;
    int         failures    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int d, input int addr);
        if (d == 0) wr_addr0 = 5'(addr);
        else        wr_addr1 = 6'(addr);
    endtask

    // Called at a negedge; the strobe covers exactly one rising edge.
    task automatic write_sample(input int d, input int addr, input logic [7:0] data,
                                input bit accept);
        wr_en[d]   = 1'b1;
        set_addr(d, addr);
        wr_data[d] = data;
        @(negedge clk);
        wr_en[d]   = 1'b0;
        if (accept && addr < depth[d]) ref_mem[d][addr] = data;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
    // abort_at >= 0 asserts rst while that beat is presented.
    task automatic run_frame(input int d, input int mode, input int abort_at, input bit wr_during);
        int         k;
        int         n;
        int         cyc;
        int         p;
        bit         r;
        logic [2:0] ef;
        frame_done[d] = 1'b1;
        n = 0;
        while (!s_valid[d] && n < 8) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("d%0d first-valid latency", d), n, 2);
        k   = 0;
        cyc = 0;
        p   = 0;
        while (k < depth[d] && cyc < 300) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("d%0d abort valid", d), s_valid[d], 0);
                check($sformatf("d%0d abort flags", d), s_flags[d], 0);
                check($sformatf("d%0d abort busy", d), busy[d], 0);
                @(negedge clk);
                rst           = 1'b0;
                frame_done[d] = 1'b0;
                repeat (2) @(negedge clk);
                return;
            end
            ef = {k == 0, (k + 1) % row_len[d] == 0, k == depth[d] - 1};
            check($sformatf("d%0d b%0d valid", d, k), s_valid[d], 1);
            check($sformatf("d%0d b%0d data", d, k), s_data[d], ref_mem[d][k]);
            check($sformatf("d%0d b%0d sof/eol/eof", d, k), s_flags[d], ef);
            check($sformatf("d%0d b%0d busy", d, k), busy[d], 1);
            case (mode)
                0:       r = 1'b1;
                1:       r = (p % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            p++;
            ready[d] = r;
            if (wr_during && k == 1) begin
                wr_en[d]   = 1'b1;
                set_addr(d, 2);
                wr_data[d] = 8'hFF;
            end
            @(negedge clk);
            wr_en[d] = 1'b0;
            cyc++;
            if (r) k++;
        end
        ready[d] = 1'b0;
        check($sformatf("d%0d beats delivered", d), k, depth[d]);
        check($sformatf("d%0d post-eof valid", d), s_valid[d], 0);
        check($sformatf("d%0d post-eof flags", d), s_flags[d], 0);
        check($sformatf("d%0d post-eof busy", d), busy[d], 0);
        // frame_done still high: no restart; a write here must be dropped.
        wr_en[d]   = 1'b1;
        set_addr(d, 3);
        wr_data[d] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en[d] = 1'b0;
            check($sformatf("d%0d held-done valid c%0d", d, i), s_valid[d], 0);
            check($sformatf("d%0d held-done busy c%0d", d, i), busy[d], 0);
        end
        frame_done[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_addr0 = '0;
        wr_addr1 = '0;
        for (int d = 0; d < 2; d++) begin
            wr_en[d]      = 1'b0;
            wr_data[d]    = '0;
            frame_done[d] = 1'b0;
            ready[d]      = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset valid", d), s_valid[d], 0);
            check($sformatf("d%0d reset data", d), s_data[d], 0);
            check($sformatf("d%0d reset flags", d), s_flags[d], 0);
            check($sformatf("d%0d reset busy", d), busy[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 4x4x1: ramp 0x10..0x1F, full-rate stream.
        for (int i = 0; i < 16; i++) write_sample(0, i, 8'(i + 16), 1'b1);
        run_frame(0, 0, -1, 1'b0);
        // Backpressure pattern with a write attempt mid-stream.
        run_frame(0, 1, -1, 1'b1);
        // New data: mem[0]=0xAA, out-of-range write, random overwrites.
        write_sample(0, 0, 8'hAA, 1'b1);
        write_sample(0, 16, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_sample(0, int'($urandom_range(0, 15)), 8'($urandom), 1'b1);
        end
        run_frame(0, 2, -1, 1'b0);
        // Reset at beat 5, then a full restart on the retained memory.
        run_frame(0, 0, 5, 1'b0);
        run_frame(0, 0, -1, 1'b0);

        // 4x2x3: random samples, repeated address, out-of-range address.
        for (int i = 0; i < 24; i++) write_sample(1, i, 8'($urandom), 1'b1);
        write_sample(1, 5, 8'h3C, 1'b1);
        write_sample(1, 5, 8'hC3, 1'b1);
        write_sample(1, 24, 8'hEE, 1'b1);
        run_frame(1, 2, -1, 1'b0);
        run_frame(1, 1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/res_stream_out.md
Name: res_stream_out

Overview:
- Readout end of the scaler's output buffer.
- Captures output pixel writes (address, data) from the mapping FSM into an internal frame store.
- When the frame is complete, streams the whole frame out in raster order (pixel-major, channel-minor) over a valid/ready interface with sof/eol/eof markers.
- Replaces the simulation-only hex dump with a synthesizable consumer-facing port.

Parameters:
W_out, 4, output image width in pixels
H_out, 4, output image height in pixels
CHANNEL, 1, channels per pixel (1..3)
DATA_W, 8, bits per channel sample
DEPTH, W_out*H_out*CHANNEL, frame store entries (derived, not overridden)
AW, $clog2(DEPTH)+1, address width (derived)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe from mapping FSM
wr_addr  input  AW  sample index ((y*W_out+x)*CHANNEL+c)
wr_data  input  DATA_W  sample value
frame_done  input  1  level, high once all samples are written (the scaler's complete)
m_valid  output  1  stream beat valid
m_ready  input  1  downstream accept
m_data  output  DATA_W  sample
m_sof  output  1  first beat of frame
m_eol  output  1  last beat of a row (last channel of column W_out-1)
m_eof  output  1  last beat of frame
busy  output  1  high in LOAD or STREAM

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rd_ptr=0; frame_done edge register=0. Memory contents are not cleared.
- Writes:
  - Accepted only in IDLE with wr_en=1 and wr_addr<DEPTH.
  - Out-of-range addresses, and any write outside IDLE, are silently dropped.
  - Last write to an address wins.
- FSM states: IDLE, LOAD, STREAM, DONE.
  - IDLE -> LOAD on a frame_done rising edge (frame_done=1 and registered previous value=0). rd_ptr=0.
  - LOAD (1 cycle): m_data<=mem[0], flags for index 0, m_valid<=1; go to STREAM. First beat is valid 2 cycles after the edge clock.
  - STREAM, handshake (m_valid&&m_ready) on beat i<DEPTH-1: load beat i+1 the next cycle. m_valid stays 1, so back-to-back beats run at 1/cycle.
  - STREAM, handshake on beat DEPTH-1: m_valid<=0, flags<=0; go to DONE.
  - STREAM, m_valid&&!m_ready: m_data, m_sof, m_eol and m_eof held stable.
  - DONE -> IDLE when frame_done=0. A frame_done held high never restarts the stream.
- Flags per beat index i:
  - m_sof = (i==0).
  - m_eol = ((i+1) mod (W_out*CHANNEL) == 0).
  - m_eof = (i==DEPTH-1).
  - Derived from separate c/x/y counters, not a divider.
  - For DEPTH=1, sof, eol and eof are all set on the same beat.
- Width rules:
  - Index counters sized AW.
  - Channel counter sized $clog2(CHANNEL)+1, so CHANNEL=1 does not produce a zero-width vector.
- A frame_done falling edge during LOAD/STREAM is ignored; the stream completes.
- Reset mid-stream aborts immediately: m_valid=0. The next frame_done edge restarts from index 0.
- Latency: frame_done edge -> first m_valid is 2 clk. A full frame with m_ready=1 takes DEPTH cycles of valid.

Decomposition:
- Shared package `scaler_pkg`:
  - FSM state encodings (2-bit, IDLE=0, LOAD=1, STREAM=2, DONE=3).
  - DATA_W default.
  - Function computing the index width from W, H and CHANNEL.
- Sub-module `res_frame_mem`:
  - Single write port, registered synchronous read port, DEPTH x DATA_W.
  - Read address driven with next-index lookahead, so beats stay back-to-back.
- FSM and counters remain in res_stream_out.

Test Plan:
- 4x4, CHANNEL=1: write mem[i]=i+0x10 for i=0..15, assert frame_done, m_ready=1 -> 16 consecutive beats 0x10..0x1F. sof at beat 0, eol at beats 3/7/11/15, eof at beat 15. First valid 2 clk after the edge.
- Backpressure, same frame: m_ready toggled 1,0,0,1,... -> m_data and flags stable whenever valid&&!ready. Output sequence still 0x10..0x1F with no loss or duplication.
- CHANNEL=3, W_out=4, H_out=2: 24 beats. eol only at beats 11 and 23, eof at 23. Write with addr=24 (out of range) -> ignored, stream unchanged.
- frame_done held high after eof -> no second stream, state DONE. Drop to 0, rewrite mem[0]=0xAA, raise again -> new stream starting 0xAA.
- Assert rst at beat 5 of a stream -> m_valid/flags 0 the same cycle, busy=0. After release, a frame_done edge restarts at index 0 with the old memory data intact.
- Writes during STREAM (addr 2, 0xFF) -> dropped. Beat 2 still outputs the pre-stream value.
